rv_core_sequencer: RTL

Parametrised multi-cycle control sequencer for the RV32I core. It replaces the free-running, enable-strapped top level with an explicit fetch/decode/execute/writeback state machine. It drives the program counter, instruction-memory handshake, decoder and register-file enables, and latches the instruction register. It adds behaviour the current core lacks: wait-state tolerant fetch, fetch timeout, trap-to-halt on system/illegal/misaligned events, and retired-instruction and cycle counters.

---
 rtl/rv_core_pkg.sv | 21 ++
 rtl/sat_counter.sv | 21 ++
 rtl/rv_core_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared types and constants for the RV32I control sequencer
// Contents:
//   state_t       sequencer states
//   CAUSE_*       halt_cause codes reported on rv_core_sequencer.halt_cause
//   INSTR_BYTES   byte stride between sequential instructions
package rv_core_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_t;
    localparam logic [2:0] CAUSE_NONE     = 3'd0;
    localparam logic [2:0] CAUSE_SYSTEM   = 3'd1;
    localparam logic [2:0] CAUSE_ILLEGAL  = 3'd2;
    localparam logic [2:0] CAUSE_MISALIGN = 3'd3;
    localparam logic [2:0] CAUSE_TIMEOUT  = 3'd4;
    localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones maximum instead of wrapping
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-high reset, clears count
//   inc    count up by one this cycle
//   count  current value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/rv_core_sequencer.sv
// rv_core_sequencer: multi-cycle fetch/decode/execute/writeback control FSM for the RV32I core
// Ports:
//   clock, reset        clock and asynchronous active-high reset
//   run, halt_clear     level run request; pulse that leaves HALT
//   imem_req/addr/ack/rdata  instruction-memory handshake
//   instr               latched instruction register
//   dec_enable, rf_read_enable, rf_write_enable  datapath enables
//   rd_nonzero, is_system, illegal  decoder status
//   branch_taken, branch_target     ALU next-PC selection
//   pc, halted, halt_cause          architectural state and halt reporting
//   retired, cycles                 saturating performance counters
module rv_core_sequencer
    import rv_core_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR  = '0,
    parameter int              CNT_W         = 32,
    parameter int              FETCH_TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             halt_clear,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             dec_enable,
    output logic             rf_read_enable,
    output logic             rf_write_enable,
    input  logic             rd_nonzero,
    input  logic             is_system,
    input  logic             illegal,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    output logic [XLEN-1:0]  pc,
    output logic             halted,
    output logic [2:0]       halt_cause,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
);
    // The wait counter holds the number of FETCH cycles already spent without
    // ack, so it only ever needs to reach FETCH_TIMEOUT-1.
    localparam int WAIT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);

    state_t            state, state_nx;
    logic [2:0]        cause_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [XLEN-1:0]   next_pc;
    logic              misalign;
    logic              timeout;
    logic              retire;
    logic              busy;

    assign next_pc   = branch_taken ? branch_target : pc + XLEN'(INSTR_BYTES);
    assign misalign  = |next_pc[1:0];
    assign timeout   = (FETCH_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);
    assign retire    = (state == ST_WRITEBACK) && !misalign;
    assign busy      = (state != ST_IDLE) && (state != ST_HALT);

    assign imem_req        = state == ST_FETCH;
    assign imem_addr       = pc;
    assign dec_enable      = state == ST_DECODE;
    assign rf_read_enable  = state == ST_DECODE;
    assign rf_write_enable = retire && rd_nonzero;

    always_comb begin
        state_nx = state;
        cause_nx = halt_cause;
        case (state)
            ST_IDLE: state_nx = run ? ST_FETCH : ST_IDLE;
            ST_FETCH: begin
                // An ack in the final allowed cycle wins over the timeout.
                if (imem_ack) begin
                    state_nx = ST_DECODE;
                end else if (timeout) begin
                    state_nx = ST_HALT;
                    cause_nx = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                state_nx = (illegal || is_system) ? ST_HALT : ST_EXECUTE;
                cause_nx = illegal ? CAUSE_ILLEGAL : is_system ? CAUSE_SYSTEM : halt_cause;
            end
            ST_EXECUTE: state_nx = ST_WRITEBACK;
            ST_WRITEBACK: begin
                state_nx = misalign ? ST_HALT : run ? ST_FETCH : ST_IDLE;
                cause_nx = misalign ? CAUSE_MISALIGN : halt_cause;
            end
            ST_HALT: begin
                state_nx = halt_clear ? ST_IDLE : ST_HALT;
                cause_nx = halt_clear ? CAUSE_NONE : halt_cause;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pc         <= RESET_VECTOR;
            instr      <= '0;
            halted     <= 1'b0;
            halt_cause <= CAUSE_NONE;
            wait_cnt   <= '0;
        end else begin
            state      <= state_nx;
            halted     <= state_nx == ST_HALT;
            halt_cause <= cause_nx;
            wait_cnt   <= (state == ST_FETCH && !imem_ack && !timeout) ? wait_cnt + 1'b1 : '0;
            if (state == ST_FETCH && imem_ack)
                instr <= imem_rdata;
            if (retire)
                pc <= next_pc;
            else if (state == ST_HALT && halt_clear)
                pc <= RESET_VECTOR;
        end
    end

    sat_counter #(.W(CNT_W)) u_retired (
        .clock (clock),
        .reset (reset),
        .inc   (retire),
        .count (retired)
    );

    sat_counter #(.W(CNT_W)) u_cycles (
        .clock (clock),
        .reset (reset),
        .inc   (busy),
        .count (cycles)
    );
endmodule
